// File: rtl/zorro2_bus_initiator.sv
// Zorro II / 68000 bus-cycle initiator: turns single-word read/write requests into
// AS/UDS/LDS/RW cycles that end on DTACK, BERR or a timeout.
module zorro2_bus_initiator #(
    parameter int SETUP_CLKS   = 2,
    parameter int WDS_CLKS     = 2,
    parameter int TIMEOUT_CLKS = 255,
    parameter int HOLD_CLKS    = 2
) (
    input  logic        mclk,
    input  logic        reset,
    input  logic        req,
    input  logic        req_rw,
    input  logic [22:0] req_addr,
    input  logic [1:0]  req_be,
    input  logic [15:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] rdata,
    output logic [22:0] A,
    output logic        AS,
    output logic        UDS,
    output logic        LDS,
    output logic        RW,
    inout  wire  [15:0] DA,
    input  logic        DTACK,
    input  logic        BERR
);

    localparam logic [7:0] SETUP_N      = 8'(SETUP_CLKS);
    localparam logic [7:0] WDS_N        = 8'(WDS_CLKS);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CLKS - 1);
    localparam logic [7:0] HOLD_LAST    = 8'(HOLD_CLKS - 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ASSERT, WAIT, SAMPLE, NEGATE, HOLD, DONE, TERM
    } state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic        err_flag;
    logic        da_oe;
    logic        dtack_m, dtack_s, berr_m, berr_s;
    logic        rw_q;
    logic [1:0]  be_q;
    logic [22:0] addr_q;
    logic [15:0] wdata_q;

    assign DA = da_oe ? wdata_q : 16'hzzzz;

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            dtack_m <= 1'b1;
            dtack_s <= 1'b1;
            berr_m  <= 1'b1;
            berr_s  <= 1'b1;
        end else begin
            dtack_m <= DTACK;
            dtack_s <= dtack_m;
            berr_m  <= BERR;
            berr_s  <= berr_m;
        end
    end

    // Request fields are only meaningful once the FSM has left IDLE, so no reset.
    always_ff @(posedge mclk) begin
        if (state == IDLE && req) begin
            rw_q    <= req_rw;
            be_q    <= req_be;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            err_flag <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            rdata    <= 16'h0000;
            A        <= 23'd0;
            AS       <= 1'b1;
            UDS      <= 1'b1;
            LDS      <= 1'b1;
            RW       <= 1'b1;
            da_oe    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        busy <= 1'b1;
                        cnt  <= 8'd0;
                        if (req_be == 2'b00) begin
                            err_flag <= 1'b1;
                            state    <= DONE;
                        end else begin
                            err_flag <= 1'b0;
                            state    <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    if (cnt == 8'd0) begin
                        A     <= addr_q;
                        RW    <= rw_q;
                        da_oe <= ~rw_q;
                    end
                    if (cnt >= SETUP_N) begin
                        AS <= 1'b0;
                        if (rw_q) begin
                            UDS   <= ~be_q[1];
                            LDS   <= ~be_q[0];
                            cnt   <= 8'd0;
                            state <= WAIT;
                        end else begin
                            cnt   <= 8'd1;
                            state <= ASSERT;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ASSERT: begin
                    if (cnt >= WDS_N) begin
                        UDS   <= ~be_q[1];
                        LDS   <= ~be_q[0];
                        cnt   <= 8'd0;
                        state <= WAIT;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WAIT: begin
                    if (!berr_s || (dtack_s && cnt == TIMEOUT_LAST)) begin
                        AS       <= 1'b1;
                        UDS      <= 1'b1;
                        LDS      <= 1'b1;
                        err_flag <= 1'b1;
                        state    <= NEGATE;
                    end else if (!dtack_s) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                SAMPLE: begin
                    if (rw_q) rdata <= DA;
                    AS    <= 1'b1;
                    UDS   <= 1'b1;
                    LDS   <= 1'b1;
                    state <= NEGATE;
                end
                // Strobes went high entering NEGATE; that cycle counts as the first hold cycle.
                NEGATE: begin
                    cnt   <= 8'd1;
                    state <= HOLD;
                end
                HOLD: begin
                    if (cnt >= HOLD_LAST) begin
                        A     <= 23'd0;
                        RW    <= 1'b1;
                        da_oe <= 1'b0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    err   <= err_flag;
                    state <= TERM;
                end
                TERM: begin
                    if (dtack_s && berr_s) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zorro2_bus_initiator.sv
// Self-checking bench for zorro2_bus_initiator: scripted slave on DTACK/BERR/DA,
// expected completions queued at request time and compared on each done pulse.
module tb_zorro2_bus_initiator;

    logic        mclk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic        req_rw = 1'b1;
    logic [22:0] req_addr = 23'd0;
    logic [1:0]  req_be = 2'b00;
    logic [15:0] req_wdata = 16'h0000;
    logic        busy, done, err;
    logic [15:0] rdata;
    logic [22:0] A;
    logic        AS, UDS, LDS, RW;
    wire  [15:0] DA;
    logic        DTACK = 1'b1;
    logic        BERR = 1'b1;
    logic [15:0] slv_data = 16'h0000;
    logic        slv_drv = 1'b0;

    // Released bus floats high so a non-driving DUT reads back as FFFF.
    assign DA = slv_drv ? slv_data : 16'hzzzz;
    for (genvar g = 0; g < 16; g++) begin : g_pu
        pullup (DA[g]);
    end

    zorro2_bus_initiator dut (
        .mclk(mclk), .reset(reset), .req(req), .req_rw(req_rw), .req_addr(req_addr),
        .req_be(req_be), .req_wdata(req_wdata), .busy(busy), .done(done), .err(err),
        .rdata(rdata), .A(A), .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW), .DA(DA),
        .DTACK(DTACK), .BERR(BERR)
    );

    always #10 mclk = ~mclk;

    typedef struct {
        logic        err;
        logic [15:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [15:0] model_rdata = 16'h0000;

    task automatic push_exp(input logic e, input logic is_read, input logic [15:0] d);
        exp_t x;
        if (!e && is_read) model_rdata = d;
        x.err   = e;
        x.rdata = model_rdata;
        sb.push_back(x);
    endtask

    task automatic start_req(input logic rw, input logic [22:0] addr, input logic [1:0] be,
                             input logic [15:0] wd);
        @(negedge mclk);
        req_rw = rw; req_addr = addr; req_be = be; req_wdata = wd; req = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge mclk);
        n_cmp++;
        if ({AS, UDS, LDS, RW} !== 4'b1111) begin
            n_fail++; $display("FAIL reset_strobes: AS/UDS/LDS/RW=%b required 1111", {AS, UDS, LDS, RW});
        end
        n_cmp++;
        if (A !== 23'd0) begin n_fail++; $display("FAIL reset_addr: A=%h required 0", A); end
        n_cmp++;
        if ({busy, done, err} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl: busy/done/err=%b required 000", {busy, done, err});
        end
        n_cmp++;
        if (rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata: rdata=%h required 0000", rdata); end
        n_cmp++;
        if (DA !== 16'hFFFF) begin n_fail++; $display("FAIL reset_da: DA=%h required released (FFFF)", DA); end
        @(negedge mclk);
        reset = 1'b1;
        repeat (2) @(negedge mclk);
    endtask

    task automatic test_latency();
        bit seen_as = 0;
        int done_k = -1;
        exp_t x;
        DTACK = 1'b0; slv_data = 16'h5A5A; slv_drv = 1'b1;
        repeat (3) @(negedge mclk);
        push_exp(1'b0, 1'b1, 16'h5A5A);
        start_req(1'b1, 23'h012345, 2'b11, 16'h0000);
        for (int k = 1; k <= 40 && done_k < 0; k++) begin
            @(negedge mclk);
            if (k == 1) req = 1'b0;
            if (!AS) seen_as = 1;
            else if (seen_as) begin DTACK = 1'b1; slv_drv = 1'b0; end
            if (done) begin
                done_k = k;
                x = sb.pop_front();
                n_cmp++;
                if (err !== x.err || rdata !== x.rdata) begin
                    n_fail++; $display("FAIL latency_result: err=%b rdata=%h required err=%b rdata=%h",
                                       err, rdata, x.err, x.rdata);
                end
            end
        end
        n_cmp++;
        if (done_k != 9) begin n_fail++; $display("FAIL latency_edges: done after %0d edges required 9", done_k); end
        DTACK = 1'b1; slv_drv = 1'b0;
        repeat (3) @(negedge mclk);
    endtask

    task automatic test_read();
        int   as_fall = -1, as_rise = -1, a_drop = -1, done_i = -1;
        bit   a_seen = 0, ign_bad = 0;
        exp_t x;
        slv_data = 16'hC000;
        push_exp(1'b0, 1'b1, 16'hC000);
        start_req(1'b1, 23'h740000, 2'b11, 16'h0000);
        for (int i = 0; i < 80; i++) begin
            @(negedge mclk);
            if (i == 0) req = 1'b0;
            if (A != 23'd0) a_seen = 1;
            else if (a_seen && a_drop < 0) a_drop = i;
            if (!AS && as_fall < 0) begin
                as_fall = i;
                n_cmp++;
                if ({UDS, LDS} !== 2'b00) begin
                    n_fail++; $display("FAIL read_strobes_together: UDS/LDS=%b required 00", {UDS, LDS});
                end
            end
            if (as_fall >= 0 && i == as_fall + 1) req = 1'b1;
            if (as_fall >= 0 && i == as_fall + 2) req = 1'b0;
            if (as_fall >= 0 && i == as_fall + 3) begin DTACK = 1'b0; slv_drv = 1'b1; end
            if (AS && as_fall >= 0 && as_rise < 0) begin as_rise = i; DTACK = 1'b1; slv_drv = 1'b0; end
            if (done_i >= 0) begin
                n_cmp++;
                if (done !== 1'b0) begin n_fail++; $display("FAIL read_done_width: done=%b one cycle later required 0", done); end
                break;
            end
            if (done) begin
                done_i = i;
                if (sb.size() == 0) begin n_cmp++; n_fail++; $display("FAIL read_result: done with nothing expected"); end
                else begin
                    x = sb.pop_front();
                    n_cmp++;
                    if (err !== x.err || rdata !== x.rdata) begin
                        n_fail++; $display("FAIL read_result: err=%b rdata=%h required err=%b rdata=%h",
                                           err, rdata, x.err, x.rdata);
                    end
                end
            end
        end
        n_cmp++;
        if (done_i < 0 || as_rise < 0 || a_drop < as_rise + 2) begin
            n_fail++; $display("FAIL read_addr_hold: AS rose at %0d, A dropped at %0d required >=2 later", as_rise, a_drop);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge mclk);
            if (!AS || busy) ign_bad = 1;
        end
        n_cmp++;
        if (ign_bad) begin n_fail++; $display("FAIL read_req_ignored: extra cycle started, required none"); end
    endtask

    task automatic test_write();
        int   as_fall = -1, ds_fall = -1;
        bit   a_seen = 0, a_gone = 0, got = 0, bad_da = 0, bad_rw = 0, bad_lds = 0;
        logic [15:0] da_after = 16'h0000;
        exp_t x;
        push_exp(1'b0, 1'b0, 16'h0000);
        start_req(1'b0, 23'h100000, 2'b10, 16'h1234);
        for (int i = 0; i < 80 && !(got && a_gone); i++) begin
            @(negedge mclk);
            if (i == 0) req = 1'b0;
            if (A != 23'd0) begin
                a_seen = 1;
                if (DA !== 16'h1234) bad_da = 1;
                if (RW !== 1'b0) bad_rw = 1;
            end else if (a_seen && !a_gone) begin
                a_gone = 1; da_after = DA;
            end
            if (!LDS) bad_lds = 1;
            if (!AS && as_fall < 0) as_fall = i;
            if (!UDS && ds_fall < 0) ds_fall = i;
            if (ds_fall >= 0 && i == ds_fall + 1) DTACK = 1'b0;
            if (AS && as_fall >= 0) DTACK = 1'b1;
            if (done) begin
                got = 1;
                x = sb.pop_front();
                n_cmp++;
                if (err !== x.err || rdata !== x.rdata) begin
                    n_fail++; $display("FAIL write_result: err=%b rdata=%h required err=%b rdata=%h",
                                       err, rdata, x.err, x.rdata);
                end
            end
        end
        n_cmp++;
        if (bad_da || !a_seen) begin n_fail++; $display("FAIL write_data: DA not 1234 for the whole cycle (seen=%b)", a_seen); end
        n_cmp++;
        if (bad_rw) begin n_fail++; $display("FAIL write_rw: RW was 1 during cycle, required 0"); end
        n_cmp++;
        if (bad_lds) begin n_fail++; $display("FAIL write_lds: LDS went low, required held 1"); end
        n_cmp++;
        if (as_fall < 0 || ds_fall - as_fall != 2) begin
            n_fail++; $display("FAIL write_ds_delay: UDS fell %0d clocks after AS required 2", ds_fall - as_fall);
        end
        n_cmp++;
        if (da_after !== 16'hFFFF) begin n_fail++; $display("FAIL write_da_release: DA=%h after hold required released (FFFF)", da_after); end
        repeat (3) @(negedge mclk);
    endtask

    task automatic test_berr();
        bit   seen = 0, got = 0;
        exp_t x;
        slv_data = 16'hFFFF;
        push_exp(1'b1, 1'b1, 16'h0000);
        start_req(1'b1, 23'h020000, 2'b11, 16'h0000);
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge mclk);
            if (i == 0) req = 1'b0;
            if (!AS && !seen) begin seen = 1; DTACK = 1'b0; BERR = 1'b0; slv_drv = 1'b1; end
            if (AS && seen) begin DTACK = 1'b1; BERR = 1'b1; slv_drv = 1'b0; end
            if (done) begin
                got = 1;
                x = sb.pop_front();
                n_cmp++;
                if (err !== x.err || rdata !== x.rdata) begin
                    n_fail++; $display("FAIL berr_result: err=%b rdata=%h required err=%b rdata=%h",
                                       err, rdata, x.err, x.rdata);
                end
            end
        end
        n_cmp++;
        if (!got) begin n_fail++; $display("FAIL berr_done: no done within bound, required one"); end
        DTACK = 1'b1; BERR = 1'b1; slv_drv = 1'b0;
        repeat (4) @(negedge mclk);
    endtask

    task automatic test_timeout();
        int   as_fall = -1, as_rise = -1, done_i = -1;
        exp_t x;
        push_exp(1'b1, 1'b1, 16'h0000);
        start_req(1'b1, 23'h7FFFFF, 2'b01, 16'h0000);
        for (int i = 0; i < 400; i++) begin
            @(negedge mclk);
            if (i == 0) req = 1'b0;
            if (!AS && as_fall < 0) as_fall = i;
            if (AS && as_fall >= 0 && as_rise < 0) as_rise = i;
            if (done_i >= 0) begin
                n_cmp++;
                if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: busy=%b after done required 0", busy); end
                break;
            end
            if (done) begin
                done_i = i;
                x = sb.pop_front();
                n_cmp++;
                if (err !== x.err || rdata !== x.rdata) begin
                    n_fail++; $display("FAIL timeout_result: err=%b rdata=%h required err=%b rdata=%h",
                                       err, rdata, x.err, x.rdata);
                end
            end
        end
        n_cmp++;
        if (as_fall < 0 || as_rise - as_fall != 255) begin
            n_fail++; $display("FAIL timeout_clocks: strobes negated %0d clocks after WAIT required 255", as_rise - as_fall);
        end
    endtask

    task automatic test_back_to_back();
        int   as_fall = -1, as2 = -1, phase = 0, hold_cnt = 0, rel_at = -1, free_at = -1;
        bit   bad_hold = 0, got2 = 0;
        exp_t x;
        slv_data = 16'h3C3C;
        push_exp(1'b0, 1'b1, 16'h3C3C);
        start_req(1'b1, 23'h000400, 2'b11, 16'h0000);
        for (int i = 0; i < 150 && !got2; i++) begin
            @(negedge mclk);
            case (phase)
                0: begin
                    if (i == 0) req = 1'b0;
                    if (!AS && as_fall < 0) as_fall = i;
                    if (as_fall >= 0 && i == as_fall + 2) begin DTACK = 1'b0; slv_drv = 1'b1; end
                    if (done) begin
                        x = sb.pop_front();
                        n_cmp++;
                        if (err !== x.err || rdata !== x.rdata) begin
                            n_fail++; $display("FAIL b2b_first: err=%b rdata=%h required err=%b rdata=%h",
                                               err, rdata, x.err, x.rdata);
                        end
                        push_exp(1'b0, 1'b0, 16'h0000);
                        req_rw = 1'b0; req_addr = 23'h000123; req_be = 2'b11; req_wdata = 16'hBEEF; req = 1'b1;
                        phase = 1;
                    end
                end
                1: begin
                    hold_cnt++;
                    if (AS !== 1'b1 || busy !== 1'b1) bad_hold = 1;
                    if (hold_cnt == 10) begin DTACK = 1'b1; slv_drv = 1'b0; rel_at = i; phase = 2; end
                end
                2: begin
                    if (busy === 1'b0) begin free_at = i; phase = 3; end
                    else if (!AS) bad_hold = 1;
                end
                3: begin req = 1'b0; phase = 4; end
                default: begin
                    if (!AS && as2 < 0) as2 = i;
                    if (as2 >= 0 && i == as2 + 2) DTACK = 1'b0;
                    if (AS && as2 >= 0) DTACK = 1'b1;
                    if (done) begin
                        got2 = 1;
                        x = sb.pop_front();
                        n_cmp++;
                        if (err !== x.err || rdata !== x.rdata) begin
                            n_fail++; $display("FAIL b2b_second: err=%b rdata=%h required err=%b rdata=%h",
                                               err, rdata, x.err, x.rdata);
                        end
                    end
                end
            endcase
        end
        req = 1'b0; DTACK = 1'b1; slv_drv = 1'b0;
        n_cmp++;
        if (bad_hold) begin n_fail++; $display("FAIL b2b_hold: cycle started or busy dropped while DTACK held"); end
        n_cmp++;
        if (free_at < 0 || rel_at < 0 || free_at < rel_at + 2) begin
            n_fail++; $display("FAIL b2b_release: busy free at %0d, DTACK released at %0d required >=2 later", free_at, rel_at);
        end
        n_cmp++;
        if (!got2) begin n_fail++; $display("FAIL b2b_second_done: second cycle never completed, required done"); end
        repeat (4) @(negedge mclk);
    endtask

    task automatic test_reset_mid();
        bit   in_wait = 0, done_seen = 0, got = 0, seen = 0;
        exp_t x;
        start_req(1'b0, 23'h055555, 2'b11, 16'hA5A5);
        for (int i = 0; i < 40 && !in_wait; i++) begin
            @(negedge mclk);
            if (i == 0) req = 1'b0;
            if (!UDS) in_wait = 1;
        end
        repeat (3) @(negedge mclk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({AS, UDS, LDS} !== 3'b111 || A !== 23'd0 || RW !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL midreset_outputs: AS/UDS/LDS=%b A=%h RW=%b busy=%b required 111/0/1/0",
                               {AS, UDS, LDS}, A, RW, busy);
        end
        n_cmp++;
        if (DA !== 16'hFFFF) begin n_fail++; $display("FAIL midreset_da: DA=%h required released (FFFF)", DA); end
        n_cmp++;
        if (rdata !== 16'h0000) begin n_fail++; $display("FAIL midreset_rdata: rdata=%h required 0000", rdata); end
        model_rdata = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge mclk);
            if (i == 2) reset = 1'b1;
            if (done) done_seen = 1;
        end
        n_cmp++;
        if (done_seen || !in_wait) begin n_fail++; $display("FAIL midreset_done: done=%b wait=%b required no done after WAIT", done_seen, in_wait); end
        slv_data = 16'h0F0F;
        push_exp(1'b0, 1'b1, 16'h0F0F);
        start_req(1'b1, 23'h000010, 2'b11, 16'h0000);
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge mclk);
            if (i == 0) req = 1'b0;
            if (!AS && !seen) begin seen = 1; DTACK = 1'b0; slv_drv = 1'b1; end
            if (AS && seen) begin DTACK = 1'b1; slv_drv = 1'b0; end
            if (done) begin
                got = 1;
                x = sb.pop_front();
                n_cmp++;
                if (err !== x.err || rdata !== x.rdata) begin
                    n_fail++; $display("FAIL midreset_next: err=%b rdata=%h required err=%b rdata=%h",
                                       err, rdata, x.err, x.rdata);
                end
            end
        end
        n_cmp++;
        if (!got) begin n_fail++; $display("FAIL midreset_next_done: no done within bound, required one"); end
        DTACK = 1'b1; slv_drv = 1'b0;
        repeat (4) @(negedge mclk);
    endtask

    task automatic test_be00();
        int   done_k = -1;
        bit   bad = 0;
        exp_t x;
        push_exp(1'b1, 1'b1, 16'h0000);
        start_req(1'b1, 23'h000777, 2'b00, 16'h0000);
        for (int k = 1; k <= 6; k++) begin
            @(negedge mclk);
            if (k == 1) req = 1'b0;
            if ({AS, UDS, LDS} !== 3'b111 || A !== 23'd0) bad = 1;
            if (done) begin
                done_k = k;
                x = sb.pop_front();
                n_cmp++;
                if (err !== x.err || rdata !== x.rdata) begin
                    n_fail++; $display("FAIL be00_result: err=%b rdata=%h required err=%b rdata=%h",
                                       err, rdata, x.err, x.rdata);
                end
            end
        end
        n_cmp++;
        if (done_k != 2) begin n_fail++; $display("FAIL be00_latency: done after %0d clocks required 2", done_k); end
        n_cmp++;
        if (bad) begin n_fail++; $display("FAIL be00_strobes: bus activity seen, required none"); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_read();
        test_write();
        test_berr();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_be00();
        n_cmp++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d completions outstanding required 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
